// File: rtl/dot_product_pkg.sv
// Shared definitions for the dot-product datapath: lane/component layout of a
// complex-sample RAM word and the read sequencer state encoding.
package dot_product_pkg;

    localparam int LANES      = 4;
    localparam int COMPONENTS = 2;
    localparam int WORDS      = LANES * COMPONENTS;

    // Word slots within a packed RAM row; slot n occupies bits [n*WIDTH +: WIDTH].
    localparam int A_REAL = 0;
    localparam int A_IMAG = 1;
    localparam int B_REAL = 2;
    localparam int B_IMAG = 3;
    localparam int C_REAL = 4;
    localparam int C_IMAG = 5;
    localparam int D_REAL = 6;
    localparam int D_IMAG = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int word_lsb(input int slot, input int width);
        return slot * width;
    endfunction

endpackage

// File: rtl/beat_fifo2.sv
// Two-entry synchronous FIFO with a registered head; dout_o is valid the cycle after push.
// Push and pop together while full keeps the count; push while full without pop is illegal.
module beat_fifo2 #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] dout_o,
    output logic [1:0]        count_o,
    output logic              empty_o,
    output logic              full_o
);

    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;
    logic [1:0]        count_q, count_d;
    logic              pop_ok;

    assign pop_ok = pop_i && (count_q != 2'd0);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case ({push_i, pop_ok})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d = din_i;
                end else begin
                    tail_d = din_i;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Count unchanged; the new word lands behind whatever remains.
                if (count_q == 2'd1) begin
                    head_d = din_i;
                end else begin
                    head_d = tail_q;
                    tail_d = din_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign dout_o  = head_q;
    assign count_o = count_q;
    assign empty_o = (count_q == 2'd0);
    assign full_o  = (count_q == 2'd2);

    assert property (@(posedge clk) disable iff (rst) !(push_i && full_o && !pop_i));

endmodule

// File: rtl/complex_bank_reader.sv
// Walks RAM addresses 0..len-1 and streams each 8-word row as one valid/ready beat.
// First beat 2 cycles after the first address; reads are throttled so the 2-entry buffer never overflows.
module complex_bank_reader
    import dot_product_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 3,
    parameter int DEPTH      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_WIDTH:0]     len,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_WIDTH-1:0]   readAddr,
    input  logic [WORDS*WIDTH-1:0]  ram_dout,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WORDS*WIDTH-1:0]  out_data,
    output logic [ADDR_WIDTH-1:0]   out_index,
    output logic                    out_last
);

    localparam int LEN_W     = ADDR_WIDTH + 1;
    localparam int DATA_BITS = WORDS * WIDTH;
    localparam int BEAT_W    = DATA_BITS + ADDR_WIDTH + 1;

    state_e                state_q, state_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [LEN_W-1:0]      issued_q, issued_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  infl_q, infl_d;
    logic [ADDR_WIDTH-1:0] infl_idx_q, infl_idx_d;
    logic                  infl_last_q, infl_last_d;

    logic [BEAT_W-1:0]     fifo_din, fifo_dout;
    logic [1:0]            fifo_count;
    logic                  fifo_empty, fifo_full;
    logic                  pop, issue;
    logic [1:0]            occ;

    beat_fifo2 #(.DATA_W(BEAT_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (infl_q),
        .pop_i   (pop),
        .din_i   (fifo_din),
        .dout_o  (fifo_dout),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // The RAM row for the in-flight address is on ram_dout this cycle.
    assign fifo_din  = {ram_dout, infl_idx_q, infl_last_q};
    assign out_data  = fifo_dout[BEAT_W-1 -: DATA_BITS];
    assign out_index = fifo_dout[1 +: ADDR_WIDTH];
    assign out_last  = fifo_dout[0];
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;

    // Credits: buffered beats plus the read still in the RAM pipeline.
    assign occ   = fifo_count + {1'b0, infl_q};
    assign issue = (state_q == RUN) && (issued_q < len_q) &&
                   ((occ < 2'd2) || ((occ == 2'd2) && pop));

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        issued_d    = issued_q;
        addr_d      = addr_q;
        infl_d      = 1'b0;
        infl_idx_d  = infl_idx_q;
        infl_last_d = infl_last_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d    = len;
                    issued_d = '0;
                    addr_d   = '0;
                    state_d  = (len != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (pop && out_last) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (issue) begin
            infl_d      = 1'b1;
            infl_idx_d  = addr_q;
            infl_last_d = (issued_q == len_q - LEN_W'(1));
            issued_d    = issued_q + LEN_W'(1);
            // Hold on the final address rather than wrapping past len-1.
            if (issued_q + LEN_W'(1) < len_q) begin
                addr_d = addr_q + ADDR_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            issued_q    <= '0;
            addr_q      <= '0;
            infl_q      <= 1'b0;
            infl_idx_q  <= '0;
            infl_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            addr_q      <= addr_d;
            infl_q      <= infl_d;
            infl_idx_q  <= infl_idx_d;
            infl_last_q <= infl_last_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign readAddr = addr_q;

    assert property (@(posedge clk) disable iff (rst)
        (state_q == IDLE && start) |-> (len <= LEN_W'(DEPTH)));

endmodule

// File: tb/tb_complex_bank_reader.sv
// Directed bench for complex_bank_reader with a registered-read RAM model.
module tb_complex_bank_reader;

    logic         clk = 1'b0;
    logic         rst, start, out_ready;
    logic [3:0]   len;
    logic         busy, done, out_valid, out_last;
    logic [2:0]   readAddr, out_index;
    logic [127:0] ram_dout, out_data;
    logic [127:0] mem [0:7];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    complex_bank_reader #(.WIDTH(16), .ADDR_WIDTH(3), .DEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .readAddr  (readAddr),
        .ram_dout  (ram_dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last)
    );

    always @(posedge clk) ram_dout <= mem[readAddr];

    function automatic logic [127:0] pat(input int k);
        logic [127:0] v;
        v = '0;
        for (int j = 0; j < 8; j++) v[j*16 +: 16] = 16'((k << 8) | j);
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; len = 4'd0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 ||
            readAddr !== 3'd0 || out_index !== 3'd0 || out_data !== 128'd0) begin
            failures++;
            $display("FAIL reset_values busy=%b done=%b vld=%b last=%b addr=%0d idx=%0d data=%h (want all 0)",
                     busy, done, out_valid, out_last, readAddr, out_index, out_data);
        end
    endtask

    task automatic test_full_run();
        logic exp;
        @(posedge clk); #1 start = 1'b1; len = 4'd8; out_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            exp = (c >= 1 && c <= 10);
            checks++;
            if (busy !== exp) begin failures++; $display("FAIL t1_busy c=%0d got=%b want=%b", c, busy, exp); end
            exp = (c == 11);
            checks++;
            if (done !== exp) begin failures++; $display("FAIL t1_done c=%0d got=%b want=%b", c, done, exp); end
            if (c >= 1 && c <= 8) begin
                checks++;
                if (readAddr !== 3'(c - 1)) begin
                    failures++; $display("FAIL t1_addr c=%0d got=%0d want=%0d", c, readAddr, c - 1);
                end
            end
            exp = (c >= 3 && c <= 10);
            checks++;
            if (out_valid !== exp) begin failures++; $display("FAIL t1_valid c=%0d got=%b want=%b", c, out_valid, exp); end
            if (exp) begin
                checks++;
                if (out_index !== 3'(c - 3) || out_data !== pat(c - 3) || out_last !== (c == 10)) begin
                    failures++;
                    $display("FAIL t1_beat c=%0d idx=%0d last=%b data=%h want idx=%0d last=%b data=%h",
                             c, out_index, out_last, out_data, c - 3, (c == 10), pat(c - 3));
                end
            end
            @(posedge clk); #1 start = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        int hs [8] = '{3, 8, 9, 10, 11, 12, 13, 14};
        int nb = 0;
        logic exp;
        @(posedge clk); #1 start = 1'b1; len = 4'd8; out_ready = 1'b1;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                checks++;
                if (nb >= 8 || c != hs[nb] || out_index !== 3'(nb) || out_data !== pat(nb) ||
                    out_last !== (nb == 7)) begin
                    failures++;
                    $display("FAIL t2_beat c=%0d idx=%0d last=%b data=%h want beat=%0d", c, out_index, out_last, out_data, nb);
                end
                nb++;
            end
            if (c >= 4 && c <= 7) begin
                checks++;
                if (out_valid !== 1'b1 || out_index !== 3'd1 || out_data !== pat(1)) begin
                    failures++;
                    $display("FAIL t2_stall_stable c=%0d vld=%b idx=%0d data=%h want vld=1 idx=1", c, out_valid, out_index, out_data);
                end
            end
            if (c >= 4 && c <= 8) begin
                checks++;
                if (readAddr !== 3'd3) begin failures++; $display("FAIL t2_addr_hold c=%0d got=%0d want=3", c, readAddr); end
            end
            exp = (c == 15);
            checks++;
            if (done !== exp) begin failures++; $display("FAIL t2_done c=%0d got=%b want=%b", c, done, exp); end
            exp = (c >= 1 && c <= 14);
            checks++;
            if (busy !== exp) begin failures++; $display("FAIL t2_busy c=%0d got=%b want=%b", c, busy, exp); end
            @(posedge clk); #1 start = 1'b0; out_ready = !((c + 1) >= 4 && (c + 1) <= 7);
        end
        checks++;
        if (nb != 8) begin failures++; $display("FAIL t2_beat_count got=%0d want=8", nb); end
    endtask

    task automatic test_len_one();
        logic exp;
        @(posedge clk); #1 start = 1'b1; len = 4'd1; out_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            exp = (c == 3);
            checks++;
            if (out_valid !== exp) begin failures++; $display("FAIL t3_valid c=%0d got=%b want=%b", c, out_valid, exp); end
            if (exp) begin
                checks++;
                if (out_index !== 3'd0 || out_last !== 1'b1 || out_data !== pat(0)) begin
                    failures++; $display("FAIL t3_beat idx=%0d last=%b data=%h want idx=0 last=1", out_index, out_last, out_data);
                end
            end
            exp = (c == 4);
            checks++;
            if (done !== exp) begin failures++; $display("FAIL t3_done c=%0d got=%b want=%b", c, done, exp); end
            exp = (c >= 1 && c <= 3);
            checks++;
            if (busy !== exp) begin failures++; $display("FAIL t3_busy c=%0d got=%b want=%b", c, busy, exp); end
            @(posedge clk); #1 start = 1'b0;
        end
    endtask

    task automatic test_len_zero();
        logic exp;
        @(posedge clk); #1 start = 1'b1; len = 4'd0; out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            exp = (c == 1);
            checks++;
            if (done !== exp || busy !== 1'b0 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL t4_zero c=%0d done=%b busy=%b vld=%b want done=%b busy=0 vld=0", c, done, busy, out_valid, exp);
            end
            @(posedge clk); #1 start = 1'b0;
        end
    endtask

    task automatic test_start_ignored();
        int nb = 0;
        logic exp;
        @(posedge clk); #1 start = 1'b1; len = 4'd8; out_ready = 1'b1;
        for (int c = 0; c < 17; c++) begin
            @(negedge clk);
            if (out_valid) begin
                checks++;
                if (out_index !== 3'(nb) || out_data !== pat(nb) || out_last !== (nb == 7)) begin
                    failures++;
                    $display("FAIL t5_beat c=%0d idx=%0d last=%b want idx=%0d last=%b", c, out_index, out_last, nb, (nb == 7));
                end
                nb++;
            end
            exp = (c == 11);
            checks++;
            if (done !== exp) begin failures++; $display("FAIL t5_done c=%0d got=%b want=%b", c, done, exp); end
            @(posedge clk); #1 start = ((c + 1) == 5); len = ((c + 1) == 5) ? 4'd3 : 4'd8;
        end
        checks++;
        if (nb != 8) begin failures++; $display("FAIL t5_beat_count got=%0d want=8", nb); end
    endtask

    task automatic test_mid_reset();
        logic exp;
        @(posedge clk); #1 start = 1'b1; len = 4'd8; out_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (c == 3 || c == 4) begin
                checks++;
                if (out_valid !== 1'b1 || out_index !== 3'(c - 3)) begin
                    failures++; $display("FAIL t6_pre c=%0d vld=%b idx=%0d want vld=1 idx=%0d", c, out_valid, out_index, c - 3);
                end
            end
            if (c == 6) begin
                checks++;
                if (busy !== 1'b0 || done !== 1'b0 || readAddr !== 3'd0 || out_index !== 3'd0 ||
                    out_data !== 128'd0 || out_last !== 1'b0) begin
                    failures++;
                    $display("FAIL t6_after_rst busy=%b done=%b addr=%0d idx=%0d last=%b data=%h want all 0",
                             busy, done, readAddr, out_index, out_last, out_data);
                end
            end
            if (c >= 6 && c <= 10) begin
                checks++;
                if (out_valid !== 1'b0) begin failures++; $display("FAIL t6_flush c=%0d vld=%b want 0", c, out_valid); end
            end
            if (c == 9 || c == 10) begin
                checks++;
                if (readAddr !== 3'(c - 9)) begin failures++; $display("FAIL t6_addr c=%0d got=%0d want=%0d", c, readAddr, c - 9); end
            end
            if (c == 11 || c == 12) begin
                checks++;
                if (out_valid !== 1'b1 || out_index !== 3'(c - 11) || out_data !== pat(c - 11) || out_last !== (c == 12)) begin
                    failures++;
                    $display("FAIL t6_beat c=%0d vld=%b idx=%0d last=%b want idx=%0d", c, out_valid, out_index, out_last, c - 11);
                end
            end
            exp = (c == 13);
            checks++;
            if (done !== exp) begin failures++; $display("FAIL t6_done c=%0d got=%b want=%b", c, done, exp); end
            @(posedge clk);
            #1 start = ((c + 1) == 8); rst = ((c + 1) == 5); len = ((c + 1) >= 8) ? 4'd2 : 4'd8;
        end
    endtask

    initial begin
        for (int k = 0; k < 8; k++) mem[k] = pat(k);
        test_reset();
        test_full_run();
        test_backpressure();
        test_len_one();
        test_len_zero();
        test_start_ignored();
        test_mid_reset();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
